clk_mon: RTL and testbench

CLK_MON -- requirements
Module: clk_mon

---
 rtl/clk_mon.sv | 109 ++++++++++
 tb/tb_clk_mon.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_mon.sv
// Measures the period of a slow, asynchronous test clock in i_clk_50M cycles and
// reports each period, an in-range flag, a running measurement count and clock loss.
module clk_mon #(
    parameter int CNT_W   = 20,
    parameter int P_MIN   = 49950,
    parameter int P_MAX   = 50050,
    parameter int TIMEOUT = 100000
) (
    input  logic             i_clk_50M,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clk_test,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_in_range,
    output logic             o_lost,
    output logic [15:0]      o_meas_cnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        LOST = 2'd3
    } state_t;

    // Limits are compared in 32 bits so CNT_W may be anything up to 32.
    localparam logic [31:0] P_MIN_U   = 32'(P_MIN);
    localparam logic [31:0] P_MAX_U   = 32'(P_MAX);
    localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       cnt_ext;
    logic              sync1, sync2, sync3;
    logic              test_rise;
    logic              in_rng;

    assign test_rise = sync2 & ~sync3;
    assign cnt_ext   = 32'(cnt);
    assign in_rng    = (cnt_ext >= P_MIN_U) && (cnt_ext <= P_MAX_U);
    assign o_state   = state;

    always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            cnt        <= '0;
            o_period   <= '0;
            o_valid    <= 1'b0;
            o_in_range <= 1'b0;
            o_lost     <= 1'b0;
            o_meas_cnt <= '0;
        end else begin
            sync1   <= i_clk_test;
            sync2   <= sync1;
            sync3   <= sync2;
            o_valid <= 1'b0;
            // Disable overrides everything, including an edge in the same cycle.
            if (!i_en) begin
                state  <= IDLE;
                cnt    <= '0;
                o_lost <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        if (test_rise) begin
                            cnt   <= CNT_ONE;
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (test_rise) begin
                            o_period   <= cnt;
                            o_valid    <= 1'b1;
                            o_in_range <= in_rng;
                            o_meas_cnt <= o_meas_cnt + 16'd1;
                            cnt        <= CNT_ONE;
                        end else if (cnt_ext >= TIMEOUT_U) begin
                            state  <= LOST;
                            o_lost <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    LOST: begin
                        // Restart timing; the next full period yields the first strobe.
                        if (test_rise) begin
                            o_lost <= 1'b0;
                            cnt    <= CNT_ONE;
                            state  <= MEAS;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: scaled-down parameters, a timestamp-based reference model
// checked every cycle, a table of period vectors and hand-written corner sequences.
module tb_clk_mon;

  localparam int M_W    = 10;
  localparam int M_PMIN = 95;
  localparam int M_PMAX = 105;
  localparam int M_TO   = 200;
  localparam int M_MAX  = (1 << M_W) - 1;

  localparam int S_W  = 6;
  localparam int S_TO = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_rst_n, i_en, i_clk_test;
  logic [M_W-1:0] o_period;
  logic           o_valid, o_in_range, o_lost;
  logic [15:0]    o_meas_cnt;
  logic [1:0]     o_state;

  logic           sat_en, sat_tv;
  logic [S_W-1:0] s_period;
  logic           s_valid, s_in_range, s_lost;
  logic [15:0]    s_meas_cnt;
  logic [1:0]     s_state;

  clk_mon #(.CNT_W(M_W), .P_MIN(M_PMIN), .P_MAX(M_PMAX), .TIMEOUT(M_TO)) u_dut (
    .i_clk_50M (clk),
    .i_rst_n   (i_rst_n),
    .i_en      (i_en),
    .i_clk_test(i_clk_test),
    .o_period  (o_period),
    .o_valid   (o_valid),
    .o_in_range(o_in_range),
    .o_lost    (o_lost),
    .o_meas_cnt(o_meas_cnt),
    .o_state   (o_state)
  );

  clk_mon #(.CNT_W(S_W), .P_MIN(1), .P_MAX(S_TO), .TIMEOUT(S_TO)) u_sat (
    .i_clk_50M (clk),
    .i_rst_n   (i_rst_n),
    .i_en      (sat_en),
    .i_clk_test(sat_tv),
    .o_period  (s_period),
    .o_valid   (s_valid),
    .o_in_range(s_in_range),
    .o_lost    (s_lost),
    .o_meas_cnt(s_meas_cnt),
    .o_state   (s_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int valid_seen = 0;
  int sat_valid_seen = 0;

  bit cur_en = 1'b0;
  bit cur_tv = 1'b0;
  bit cur_rst = 1'b0;

  // Reference model: time since the last recognised rise of the test clock.
  bit [2:0]       hist = '0;
  bit             m_idle = 1'b1;
  bit             m_have_ref = 1'b0;
  bit             m_lost = 1'b0;
  int             m_ref = 0;
  logic [M_W-1:0] m_period = '0;
  bit             m_valid = 1'b0;
  bit             m_in_range = 1'b0;
  logic [15:0]    m_cnt = '0;

  typedef struct {
    int hi;
    int lo;
    int periods;
    int exp_period;
    bit exp_in_range;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_update();
    bit rise;
    int elapsed;
    // A rise applied at the input is recognised two clock edges later.
    rise = hist[1] & ~hist[2];
    hist = {hist[1:0], cur_tv};
    m_valid = 1'b0;
    if (!cur_rst) begin
      hist = '0;
      m_idle = 1'b1; m_have_ref = 1'b0; m_lost = 1'b0;
      m_period = '0; m_in_range = 1'b0; m_cnt = '0;
    end else if (!cur_en) begin
      m_idle = 1'b1; m_have_ref = 1'b0; m_lost = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (rise) begin
      if (m_have_ref && !m_lost) begin
        elapsed = cyc - m_ref;
        if (elapsed > M_MAX) elapsed = M_MAX;
        m_period = M_W'(elapsed);
        m_valid = 1'b1;
        m_in_range = (elapsed >= M_PMIN) && (elapsed <= M_PMAX);
        m_cnt = m_cnt + 16'd1;
      end
      m_lost = 1'b0;
      m_have_ref = 1'b1;
      m_ref = cyc;
    end else if (m_have_ref && !m_lost && (cyc - m_ref) >= M_TO) begin
      m_lost = 1'b1;
    end
  endtask

  task automatic step();
    logic [1:0] m_state;
    i_en = cur_en;
    i_clk_test = cur_tv;
    i_rst_n = cur_rst;
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    if (o_valid) valid_seen++;
    if (s_valid) sat_valid_seen++;
    m_state = m_idle ? 2'd0 : (!m_have_ref ? 2'd1 : (m_lost ? 2'd3 : 2'd2));
    n_total++;
    if (o_period === m_period && o_valid === m_valid && o_in_range === m_in_range &&
        o_lost === m_lost && o_meas_cnt === m_cnt && o_state === m_state)
      n_pass++;
    else
      $display("FAIL model cyc=%0d period %0d exp %0d valid %0b exp %0b in_range %0b exp %0b lost %0b exp %0b meas %0d exp %0d state %0d exp %0d",
               cyc, o_period, m_period, o_valid, m_valid, o_in_range, m_in_range,
               o_lost, m_lost, o_meas_cnt, m_cnt, o_state, m_state);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_clock(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      cur_tv = 1'b1; steps(hi);
      cur_tv = 1'b0; steps(lo);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int v0, n_rise, seg_hi, seg_lo;

    vecs[0] = '{50, 50, 3, 100, 1'b1};
    vecs[1] = '{60, 60, 3, 120, 1'b0};
    vecs[2] = '{50, 50, 3, 100, 1'b1};
    vecs[3] = '{48, 47, 3,  95, 1'b1};
    vecs[4] = '{53, 52, 3, 105, 1'b1};
    vecs[5] = '{47, 47, 3,  94, 1'b0};
    vecs[6] = '{53, 53, 3, 106, 1'b0};
    vecs[7] = '{20, 30, 4,  50, 1'b0};

    sat_en = 1'b0; sat_tv = 1'b0;
    i_rst_n = 1'b0; i_en = 1'b0; i_clk_test = 1'b0;

    // Reset state
    cur_rst = 1'b0; steps(3);
    check("reset_outputs", int'({o_period, o_valid, o_in_range, o_lost, o_meas_cnt}), 0);
    check("reset_state", int'(o_state), 0);
    cur_rst = 1'b1; cur_en = 1'b0; steps(2);
    check("disabled_idle", int'(o_state), 0);

    // First edge gives no strobe, later edges count 1, 2, 3
    cur_en = 1'b1; steps(5);
    run_clock(50, 50, 1);
    check("first_edge_no_strobe", valid_seen, 0);
    run_clock(50, 50, 3);
    check("three_strobes", valid_seen, 3);
    check("meas_cnt_3", int'(o_meas_cnt), 3);
    check("nominal_period", int'(o_period), 100);
    check("nominal_in_range", int'(o_in_range), 1);

    // Table of periods, including both range limits and just outside them
    foreach (vecs[k]) begin
      run_clock(vecs[k].hi, vecs[k].lo, vecs[k].periods);
      check($sformatf("vec%0d_period", k), int'(o_period), vecs[k].exp_period);
      check($sformatf("vec%0d_in_range", k), int'(o_in_range), int'(vecs[k].exp_in_range));
    end

    // Loss: test clock held low after a rise
    cur_tv = 1'b1; step(); n_rise = cyc;
    steps(49);
    v0 = valid_seen;
    cur_tv = 1'b0;
    for (int i = 0; i < 400 && !o_lost; i++) step();
    check("lost_latency", cyc - n_rise, M_TO + 2);
    check("lost_no_strobe", valid_seen, v0);
    steps(30);
    check("lost_held", int'(o_lost), 1);
    run_clock(50, 50, 1);
    check("resume_lost_cleared", int'(o_lost), 0);
    check("resume_no_strobe", valid_seen, v0);
    cur_tv = 1'b1;
    for (int i = 0; i < 10 && !o_valid; i++) step();
    check("resume_strobe", valid_seen, v0 + 1);
    check("resume_period", int'(o_period), 100);

    // Reset mid-period
    steps(19);
    cur_tv = 1'b0; steps(10);
    cur_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midreset_outputs", int'({o_period, o_valid, o_in_range, o_lost, o_meas_cnt}), 0);
    end
    cur_rst = 1'b1;
    v0 = valid_seen;
    steps(5);
    run_clock(50, 50, 1);
    check("post_reset_first_edge", valid_seen, v0);
    cur_tv = 1'b1; steps(10);
    check("post_reset_strobe", valid_seen, v0 + 1);
    check("post_reset_meas_cnt", int'(o_meas_cnt), 1);
    check("post_reset_period", int'(o_period), 100);

    // Disable in the same cycle the edge is recognised
    cur_tv = 1'b0; steps(40);
    v0 = valid_seen;
    cur_tv = 1'b1; step(); step();
    cur_en = 1'b0; step();
    check("disable_edge_valid", int'(o_valid), 0);
    check("disable_edge_state", int'(o_state), 0);
    check("disable_edge_period", int'(o_period), 100);
    check("disable_edge_count", valid_seen, v0);
    cur_en = 1'b1; steps(20);

    // Randomised segments checked against the model every cycle
    for (int s = 0; s < 40; s++) begin
      seg_hi = $urandom_range(3, 70);
      seg_lo = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 260) : $urandom_range(3, 70);
      if ($urandom_range(0, 11) == 0) begin
        cur_en = 1'b0; steps($urandom_range(1, 5)); cur_en = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) begin
        cur_rst = 1'b0; steps(2); cur_rst = 1'b1;
      end
      run_clock(seg_hi, seg_lo, 1);
    end
    cur_rst = 1'b1; cur_en = 1'b1;

    // Full-scale counter: TIMEOUT equal to the counter maximum
    sat_en = 1'b1; sat_tv = 1'b0; steps(3);
    sat_tv = 1'b1; step(); n_rise = cyc;
    steps(5);
    sat_tv = 1'b0;
    for (int i = 0; i < 200 && !s_lost; i++) step();
    check("sat_lost_latency", cyc - n_rise, S_TO + 2);
    steps(100);
    check("sat_lost_held", int'(s_lost), 1);
    check("sat_state_lost", int'(s_state), 3);
    check("sat_no_strobe", sat_valid_seen, 0);
    check("sat_period_untouched", int'(s_period), 0);
    sat_tv = 1'b1; steps(30);
    sat_tv = 1'b0; steps(33);
    sat_tv = 1'b1;
    for (int i = 0; i < 10 && !s_valid; i++) step();
    check("sat_full_period", int'(s_period), S_TO);
    check("sat_full_in_range", int'(s_in_range), 1);
    check("sat_lost_cleared", int'(s_lost), 0);
    check("sat_one_strobe", sat_valid_seen, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
